// File: rtl/mac_pkg.sv
// Shared types, state encoding and sign-magnitude helpers for the serial MAC layer sequencer.
package mac_pkg;

   localparam int SM_W       = 8;
   localparam int SM_MAG_W   = 7;
   localparam int PROD_MAG_W = 2 * SM_MAG_W;
   localparam int PROD_W     = PROD_MAG_W + 1;
   localparam int CONV_W     = 64;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_EMIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN,
      EMIT  = ST_EMIT,
      DONE  = ST_DONE
   } state_t;

   // Address/index width that never collapses to zero bits for a count of one.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [PROD_W-1:0] sm_to_tc(input logic sign,
                                                         input logic [PROD_MAG_W-1:0] mag);
      logic signed [PROD_W-1:0] v;
      v = signed'({1'b0, mag});
      return sign ? -v : v;
   endfunction

   // Result packs the magnitude in [mag_w-1:0] and the sign at bit mag_w, upper bits zero,
   // so the caller can take exactly mag_w+1 bits with a size cast.
   function automatic logic [CONV_W-1:0] tc_to_sm_sat(input logic signed [CONV_W-1:0] v,
                                                      input int unsigned mag_w);
      logic [CONV_W-1:0] abs_v;
      logic [CONV_W-1:0] lim;
      logic [CONV_W-1:0] mag;
      abs_v = v[CONV_W-1] ? unsigned'(-v) : unsigned'(v);
      lim   = (CONV_W'(1) << mag_w) - CONV_W'(1);
      mag   = (abs_v > lim) ? lim : abs_v;
      return mag | (CONV_W'(v[CONV_W-1]) << mag_w);
   endfunction

endpackage

// File: rtl/mac_layer_sequencer_acc.sv
// Sign-magnitude product into a registered two's-complement accumulator.
// acc_next exposes the value being written so the final product can be converted without an extra cycle.
module sm_mac_acc
   import mac_pkg::*;
#(
   parameter int ACC_W = 22
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic [SM_W-1:0]         a,
   input  logic [SM_W-1:0]         w,
   output logic signed [ACC_W-1:0] acc_next
);

   logic [PROD_MAG_W-1:0]    prod_mag;
   logic signed [PROD_W-1:0] prod_tc;
   logic signed [ACC_W-1:0]  acc;

   assign prod_mag = PROD_MAG_W'(a[SM_MAG_W-1:0]) * PROD_MAG_W'(w[SM_MAG_W-1:0]);
   // Negative zero yields a zero magnitude, so it contributes nothing regardless of sign.
   assign prod_tc  = sm_to_tc(a[SM_W-1] ^ w[SM_W-1], prod_mag);

   always_comb begin
      acc_next = acc;
      if (clr)
         acc_next = '0;
      else if (en)
         acc_next = acc + ACC_W'(prod_tc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else
         acc <= acc_next;
   end

endmodule

// File: rtl/mac_layer_sequencer.sv
// Fully-connected layer sequencer: streams activation/weight pairs through one serial MAC
// and hands out one saturated sign-magnitude result per neuron over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing a_addr/w_addr for element i of neuron j
// DRAIN | absorbing the last product, converting and registering the result
// EMIT  | out_valid high, waiting for out_ready
// DONE  | one-cycle done pulse
module mac_layer_sequencer
   import mac_pkg::*;
#(
   parameter int N_IN  = 62,
   parameter int N_OUT = 30,
   parameter int MAG_W = 20
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   output logic                                   busy,
   output logic                                   done,
   output logic [clog2_min1(N_IN)-1:0]            a_addr,
   input  logic [SM_W-1:0]                        a_data,
   output logic [clog2_min1(N_IN*N_OUT)-1:0]      w_addr,
   input  logic [SM_W-1:0]                        w_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [MAG_W:0]                         out_data,
   output logic [clog2_min1(N_OUT)-1:0]           out_idx
);

   localparam int AW    = clog2_min1(N_IN);
   localparam int WW    = clog2_min1(N_IN * N_OUT);
   localparam int JW    = clog2_min1(N_OUT);
   localparam int ACC_W = $clog2(N_IN) + 16;

   localparam logic [AW-1:0] I_LAST = AW'(N_IN - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

   state_t state, state_nxt;

   logic [AW-1:0] i_cnt;
   logic [JW-1:0] j_cnt;
   logic [WW-1:0] w_ptr;
   logic          vld_d;
   logic          issue;
   logic          acc_clr;
   logic          load_out;
   logic          xfer;
   logic          go;

   logic signed [ACC_W-1:0] acc_next;
   logic [MAG_W:0]          out_sm;

   assign go = (state == IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      acc_clr   = 1'b0;
      load_out  = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               acc_clr   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            issue = 1'b1;
            if (i_cnt == I_LAST)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            load_out  = 1'b1;
            state_nxt = EMIT;
         end
         EMIT: begin
            if (out_ready) begin
               xfer = 1'b1;
               if (j_cnt == J_LAST) begin
                  state_nxt = DONE;
               end else begin
                  acc_clr   = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // w_ptr walks j*N_IN+i linearly; it holds on the last element so addresses stay frozen in EMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_cnt <= '0;
         j_cnt <= '0;
         w_ptr <= '0;
         vld_d <= 1'b0;
      end else begin
         vld_d <= issue;
         if (go) begin
            i_cnt <= '0;
            j_cnt <= '0;
            w_ptr <= '0;
         end else if (issue && (i_cnt != I_LAST)) begin
            i_cnt <= i_cnt + AW'(1);
            w_ptr <= w_ptr + WW'(1);
         end else if (xfer && (j_cnt != J_LAST)) begin
            i_cnt <= '0;
            j_cnt <= j_cnt + JW'(1);
            w_ptr <= w_ptr + WW'(1);
         end
      end
   end

   sm_mac_acc #(
      .ACC_W (ACC_W)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr),
      .en       (vld_d),
      .a        (a_data),
      .w        (w_data),
      .acc_next (acc_next)
   );

   assign out_sm = (MAG_W + 1)'(tc_to_sm_sat(CONV_W'(acc_next), MAG_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_idx  <= '0;
      end else if (load_out) begin
         out_data <= out_sm;
         out_idx  <= j_cnt;
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign out_valid = (state == EMIT);
   assign a_addr    = i_cnt;
   assign w_addr    = w_ptr;

endmodule
